tp_pattern_gen: RTL
===================

TP_PATTERN_GEN -- requirements
Module: tp_pattern_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per colour component.
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, meaning horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, meaning vertical timing in lines.
REQ-004 SHALL have parameter CHK_LOG2, default 5, meaning checker square side = 2**CHK_LOG2 pixels.
REQ-005 SHALL have parameter SYNC_POL, default 0, meaning sync active level (0 = active-low).
REQ-006 SHALL have port px_clk  in  1  pixel clock, sole clock.
REQ-007 SHALL have port sys_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port enable_i  in  1  run/stop timing generation.
REQ-009 SHALL have port mode_i  in  2  pattern select: 0 bars, 1 gradient, 2 checker, 3 solid.
REQ-010 SHALL have ports solid_r_i/solid_g_i/solid_b_i  in  DATA_W  solid colour.
REQ-011 SHALL have ports vsync_o, hsync_o, dval_o  out  1  sync strobes and active-video flag.
REQ-012 SHALL have ports rdata_o/gdata_o/bdata_o  out  DATA_W  pixel components.
REQ-013 SHALL have ports sof_o, eol_o  out  1  first active pixel of frame / last active pixel of line.
REQ-014 SHALL have port frame_cnt_o  out  16  completed-frame count.

Function
REQ-015 SHALL run h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, v_cnt advancing when h_cnt wraps; TOTAL = ACTIVE+FP+SYNC+BP.
REQ-016 SHALL assert dval_o when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-017 SHALL drive hsync_o to SYNC_POL level for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else inverse; vsync_o likewise on v_cnt.
REQ-018 SHALL register all outputs: fixed 1-cycle latency from counter state to outputs, all outputs aligned.
REQ-019 SHALL drive rdata_o/gdata_o/bdata_o to 0 whenever dval_o is 0.
REQ-020 SHALL latch mode_i and solid_*_i only at h_cnt==0 && v_cnt==0; mid-frame changes take effect next frame.
REQ-021 Mode 0 SHALL output 8 equal bars, index = h_cnt/(H_ACTIVE/8), order white,yellow,cyan,green,magenta,red,blue,black, components all-ones or 0.
REQ-022 Mode 1 SHALL output all components = x[DATA_W-1:0], wrapping modulo 2**DATA_W.
REQ-023 Mode 2 SHALL output all-ones when x[CHK_LOG2]^v_cnt[CHK_LOG2]==1, else 0.
REQ-024 Mode 3 SHALL output the latched solid colour.
REQ-025 SHALL pulse sof_o with the pixel at h_cnt==0,v_cnt==0; eol_o with the pixel at h_cnt==H_ACTIVE-1 on active lines.
REQ-026 SHALL increment frame_cnt_o at the last cycle of each frame, wrapping 0xFFFF->0.
REQ-027 With enable_i low, counters SHALL hold at 0, dval_o/sof_o/eol_o 0, syncs inactive; restart on enable_i high begins at h_cnt=0,v_cnt=0.
REQ-028 Deassertion of enable_i mid-frame SHALL abort the frame immediately without incrementing frame_cnt_o.

Reset
REQ-029 On sys_rst_n low SHALL clear counters, latched mode (0), latched colour (0), frame_cnt_o, data outputs, dval_o, sof_o, eol_o, and drive syncs inactive.
REQ-030 Reset release SHALL start the first frame at h_cnt=0,v_cnt=0 on the first px_clk edge with enable_i high.

Configuration
REQ-031 With TPG_MOVING_EN defined, x SHALL be h_cnt + frame_cnt_o (truncated), scrolling modes 1 and 2 by one pixel per frame; without it, x = h_cnt.

Structure
REQ-032 SHALL place the mode enum, bar colour table and TOTAL/width-derivation functions in package tp_pkg.
REQ-033 SHALL implement counters and sync/dval decode in sub-module tp_timing; pattern muxing stays in the top.

Verification (small params: H 16/2/2/2, V 8/1/1/1, DATA_W 8, CHK_LOG2 2)
REQ-034 Reset then enable, mode 0 -> first active line R/G/B = FF,FF,FF for pixels 0-1, FF,FF,00 for 2-3, ... 00,00,00 for 14-15; dval_o 16 cycles/line.
REQ-035 Mode 1, macro off -> pixel n of every line = n; macro on, frame 3 -> pixel n = n+3.
REQ-036 Mode 2 -> pixels 0-3 of line 0 = 00, 4-7 = FF; line 4 inverted.
REQ-037 Switch mode 0->3 (solid 12,34,56) mid-frame -> current frame stays bars, next frame all pixels 12,34,56.
REQ-038 Assert sys_rst_n low mid-line -> all outputs to reset values immediately; after release, sof_o one cycle after first enabled edge, frame_cnt_o=0.
REQ-039 Run 3 frames with SYNC_POL 0 -> hsync_o low exactly 2 cycles/line, vsync_o low 1 line/frame, frame_cnt_o=3.

Source files
------------

// File: rtl/tp_pkg.sv
// ============================================================================
// Module      : tp_pkg
// Description : Shared types, bar colour table and timing helpers for the
//               test-pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tp_pkg;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_GRAD  = 2'd1,
    MODE_CHK   = 2'd2,
    MODE_SOLID = 2'd3
  } tp_mode_e;

  localparam int C_NUM_BARS = 8;

  // {R,G,B} on/off per bar, left to right
  localparam logic [2:0] C_BAR_RGB [C_NUM_BARS] = '{
    3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000
  };

  function automatic int tp_total(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction

  function automatic int tp_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1; never narrower than 4 bits so the bar index slice is valid
  function automatic int tp_width(input int n);
    return tp_max($clog2(n), 4);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tp_timing.sv
// ============================================================================
// Module      : tp_timing
// Description : Horizontal/vertical raster counters with active, sync,
//               start-of-frame, end-of-line and end-of-frame decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tp_timing
  import tp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HW       = 10,
  parameter int VW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_active,
  output logic          o_sof,
  output logic          o_eol,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_frame_end
);

  localparam int H_TOTAL = tp_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = tp_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HW-1:0] C_H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] C_H_EOL  = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] C_H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] C_HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] C_H_ONE  = HW'(1);
  localparam logic [VW-1:0] C_V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] C_V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] C_VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] C_V_ONE  = VW'(1);

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_v_act;

  assign w_h_wrap = (r_h == C_H_LAST);
  assign w_v_wrap = (r_v == C_V_LAST);
  assign w_v_act  = (r_v < C_V_ACT);

  // Disabling parks the raster at the origin, which also aborts a partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (!i_en) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_wrap) begin
      r_h <= '0;
      r_v <= w_v_wrap ? '0 : (r_v + C_V_ONE);
    end else begin
      r_h <= r_h + C_H_ONE;
    end
  end

  assign o_h_cnt     = r_h;
  assign o_v_cnt     = r_v;
  assign o_active    = i_en & (r_h < C_H_ACT) & w_v_act;
  assign o_sof       = i_en & (r_h == '0) & (r_v == '0);
  assign o_eol       = i_en & (r_h == C_H_EOL) & w_v_act;
  assign o_hs        = i_en & (r_h >= C_HS_BEG) & (r_h < C_HS_END);
  assign o_vs        = i_en & (r_v >= C_VS_BEG) & (r_v < C_VS_END);
  assign o_frame_end = i_en & w_h_wrap & w_v_wrap;

endmodule

`default_nettype wire

// File: rtl/tp_pattern_gen.sv
// ============================================================================
// Module      : tp_pattern_gen
// Description : Video test-pattern generator (bars, gradient, checker, solid)
//               with registered, aligned sync/data outputs.
//               Define TPG_MOVING_EN to scroll gradient/checker by frame count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tp_pattern_gen
  import tp_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CHK_LOG2 = 5,
  parameter int SYNC_POL = 0
) (
  input  logic              px_clk,
  input  logic              sys_rst_n,
  input  logic              enable_i,
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] solid_r_i,
  input  logic [DATA_W-1:0] solid_g_i,
  input  logic [DATA_W-1:0] solid_b_i,
  output logic              vsync_o,
  output logic              hsync_o,
  output logic              dval_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] gdata_o,
  output logic [DATA_W-1:0] bdata_o,
  output logic              sof_o,
  output logic              eol_o,
  output logic [15:0]       frame_cnt_o
);

  localparam int HW      = tp_width(tp_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1);
  localparam int VW      = tp_width(tp_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1);
  localparam int XW      = tp_max(DATA_W, CHK_LOG2 + 1);
  localparam int C_BAR_W = (H_ACTIVE >= C_NUM_BARS) ? (H_ACTIVE / C_NUM_BARS) : 1;

  localparam logic [HW-1:0] C_BAR_DIV = HW'(C_BAR_W);
  localparam logic [HW-1:0] C_BAR_MAX = HW'(C_NUM_BARS - 1);
  localparam logic [XW-1:0] C_X_CHK   = XW'(1) << CHK_LOG2;
  localparam logic [VW-1:0] C_V_CHK   = VW'(1) << CHK_LOG2;
  localparam logic          C_SYNC_ON = (SYNC_POL != 0);

  logic [HW-1:0]     w_h;
  logic [VW-1:0]     w_v;
  logic              w_active, w_sof, w_eol, w_hs, w_vs, w_frame_end;
  logic [XW-1:0]     w_x;
  logic [HW-1:0]     w_bar_q;
  logic [2:0]        w_bar_idx;
  logic [2:0]        w_bar_rgb;
  logic              w_chk;
  tp_mode_e          w_mode;
  logic [DATA_W-1:0] w_sr, w_sg, w_sb;
  logic [DATA_W-1:0] w_r, w_g, w_b;

  tp_mode_e          r_mode;
  logic [DATA_W-1:0] r_solid_r, r_solid_g, r_solid_b;
  logic [15:0]       r_frame_cnt;
  logic              r_dval, r_sof, r_eol, r_hsync, r_vsync;
  logic [DATA_W-1:0] r_r, r_g, r_b;

  tp_timing #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .HW       (HW),       .VW   (VW)
  ) u_timing (
    .clk         (px_clk),
    .rst_n       (sys_rst_n),
    .i_en        (enable_i),
    .o_h_cnt     (w_h),
    .o_v_cnt     (w_v),
    .o_active    (w_active),
    .o_sof       (w_sof),
    .o_eol       (w_eol),
    .o_hs        (w_hs),
    .o_vs        (w_vs),
    .o_frame_end (w_frame_end)
  );

`ifdef TPG_MOVING_EN
  assign w_x = XW'(w_h) + XW'(r_frame_cnt);
`else
  assign w_x = XW'(w_h);
`endif

  // The origin pixel uses the inputs directly so a newly latched setting covers the whole frame
  assign w_mode = w_sof ? tp_mode_e'(mode_i) : r_mode;
  assign w_sr   = w_sof ? solid_r_i : r_solid_r;
  assign w_sg   = w_sof ? solid_g_i : r_solid_g;
  assign w_sb   = w_sof ? solid_b_i : r_solid_b;

  assign w_bar_q   = w_h / C_BAR_DIV;
  assign w_bar_idx = (w_bar_q > C_BAR_MAX) ? 3'(C_NUM_BARS - 1) : w_bar_q[2:0];
  assign w_bar_rgb = C_BAR_RGB[w_bar_idx];
  assign w_chk     = (|(w_x & C_X_CHK)) ^ (|(w_v & C_V_CHK));

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    if (w_active) begin
      case (w_mode)
        MODE_BARS: begin
          w_r = {DATA_W{w_bar_rgb[2]}};
          w_g = {DATA_W{w_bar_rgb[1]}};
          w_b = {DATA_W{w_bar_rgb[0]}};
        end
        MODE_GRAD: begin
          w_r = w_x[DATA_W-1:0];
          w_g = w_x[DATA_W-1:0];
          w_b = w_x[DATA_W-1:0];
        end
        MODE_CHK: begin
          w_r = {DATA_W{w_chk}};
          w_g = {DATA_W{w_chk}};
          w_b = {DATA_W{w_chk}};
        end
        default: begin
          w_r = w_sr;
          w_g = w_sg;
          w_b = w_sb;
        end
      endcase
    end
  end

  always_ff @(posedge px_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode    <= MODE_BARS;
      r_solid_r <= '0;
      r_solid_g <= '0;
      r_solid_b <= '0;
    end else if (w_sof) begin
      r_mode    <= tp_mode_e'(mode_i);
      r_solid_r <= solid_r_i;
      r_solid_g <= solid_g_i;
      r_solid_b <= solid_b_i;
    end
  end

  always_ff @(posedge px_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_dval      <= 1'b0;
      r_sof       <= 1'b0;
      r_eol       <= 1'b0;
      r_hsync     <= ~C_SYNC_ON;
      r_vsync     <= ~C_SYNC_ON;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_dval  <= w_active;
      r_sof   <= w_sof;
      r_eol   <= w_eol;
      r_hsync <= w_hs ? C_SYNC_ON : ~C_SYNC_ON;
      r_vsync <= w_vs ? C_SYNC_ON : ~C_SYNC_ON;
      r_r     <= w_r;
      r_g     <= w_g;
      r_b     <= w_b;
      if (w_frame_end) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign dval_o      = r_dval;
  assign sof_o       = r_sof;
  assign eol_o       = r_eol;
  assign hsync_o     = r_hsync;
  assign vsync_o     = r_vsync;
  assign rdata_o     = r_r;
  assign gdata_o     = r_g;
  assign bdata_o     = r_b;
  assign frame_cnt_o = r_frame_cnt;

endmodule

`default_nettype wire
